// File: rtl/corelet_ctrl_if.sv
//------------------------------------------------------------------------------
// corelet_ctrl_if : corelet handshake plus input/output SRAM bus of one tile
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface corelet_ctrl_if #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int PSUM_BW = 16,
  parameter int INST_BW = 16,
  parameter int ADDR_BW = 11
);
  logic [INST_BW-1:0]      inst;
  logic [3:0]              req;
  logic [3:0]              ack;
  logic [4*ROWS-1:0]       cin;
  logic [PSUM_BW*COLS-1:0] cout;

  logic                    imem_rd;
  logic [ADDR_BW-1:0]      imem_addr;
  logic [4*ROWS-1:0]       imem_rdata;

  logic                    omem_wr;
  logic [ADDR_BW-1:0]      omem_addr;
  logic [PSUM_BW*COLS-1:0] omem_wdata;

  modport master (
    output inst, ack, cin, imem_rd, imem_addr, omem_wr, omem_addr, omem_wdata,
    input  req, cout, imem_rdata
  );

  modport slave (
    input  inst, ack, cin, imem_rd, imem_addr, omem_wr, omem_addr, omem_wdata,
    output req, cout, imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/corelet_ctrl.sv
//------------------------------------------------------------------------------
// corelet_ctrl : per-tile sequencer (new-cycle, weight/activation load, drain)
// Optional busy-cycle counter: define CORELET_CTRL_PERF_CNT_EN
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module corelet_ctrl #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int PSUM_BW = 16,
  parameter int INST_BW = 16,
  parameter int ADDR_BW = 11,
  parameter int W_BASE  = 0,
  parameter int A_BASE  = 64,
  parameter int O_BASE  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  a_len,
  output logic        busy,
  output logic        done,
  output logic [31:0] perf_cycles,
  corelet_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NEWCYC = 3'd1;
  localparam logic [2:0] S_WAIT_W = 3'd2;
  localparam logic [2:0] S_LOAD_W = 3'd3;
  localparam logic [2:0] S_WAIT_A = 3'd4;
  localparam logic [2:0] S_LOAD_A = 3'd5;
  localparam logic [2:0] S_DRAIN  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [7:0]         c_ROWS   = 8'(ROWS);
  localparam logic [ADDR_BW-1:0] c_W_BASE = ADDR_BW'(W_BASE);
  localparam logic [ADDR_BW-1:0] c_A_BASE = ADDR_BW'(A_BASE);
  localparam logic [ADDR_BW-1:0] c_O_BASE = ADDR_BW'(O_BASE);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_a_len;
  logic [7:0] r_rcnt;
  logic [7:0] r_ocnt;
  logic       r_rd_valid;

  logic       w_start_ok;
  logic       w_loading;
  logic [7:0] w_load_len;
  logic       w_rd;
  logic       w_last_ack;
  logic       w_wr;
  logic [7:0] w_ocnt_nxt;
  logic       w_done;
  logic       w_unused_req;

  assign w_start_ok = (r_state == S_IDLE) && start && (a_len != 8'd0);
  assign w_loading  = (r_state == S_LOAD_W) || (r_state == S_LOAD_A);
  assign w_load_len = (r_state == S_LOAD_W) ? c_ROWS : r_a_len;

  // Reads run ahead of acks by one cycle; the stream ends on the ack that
  // follows the final read.
  assign w_rd       = w_loading && (r_rcnt != w_load_len);
  assign w_last_ack = w_loading && r_rd_valid && (r_rcnt == w_load_len);

  // Writes stop once a_len rows have landed, so a late req[2] cannot overrun.
  assign w_wr       = ((r_state == S_LOAD_A) || (r_state == S_DRAIN)) &&
                      bus.req[2] && (r_ocnt != r_a_len);
  assign w_ocnt_nxt = r_ocnt + 8'd1;
  assign w_done     = (r_state == S_DRAIN) &&
                      ((r_ocnt == r_a_len) || (w_wr && (w_ocnt_nxt == r_a_len)));

  assign w_unused_req = bus.req[3];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok) w_state_nxt = S_NEWCYC;
      S_NEWCYC: w_state_nxt = S_WAIT_W;
      S_WAIT_W: if (bus.req[0]) w_state_nxt = S_LOAD_W;
      S_LOAD_W: if (w_last_ack) w_state_nxt = S_WAIT_A;
      S_WAIT_A: if (bus.req[1]) w_state_nxt = S_LOAD_A;
      S_LOAD_A: if (w_last_ack) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (w_done) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_a_len    <= 8'd0;
      r_rcnt     <= 8'd0;
      r_ocnt     <= 8'd0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_valid <= w_rd;
      if (w_start_ok) begin
        r_a_len <= a_len;
      end
      if ((r_state == S_WAIT_W) || (r_state == S_WAIT_A)) begin
        r_rcnt <= 8'd0;
      end else if (w_rd) begin
        r_rcnt <= r_rcnt + 8'd1;
      end
      if (w_start_ok) begin
        r_ocnt <= 8'd0;
      end else if (w_wr) begin
        r_ocnt <= w_ocnt_nxt;
      end
    end
  end

  always_comb begin
    bus.inst    = '0;
    bus.inst[4] = (r_state == S_NEWCYC);
  end

  assign bus.ack[0] = (r_state == S_LOAD_W) && r_rd_valid;
  assign bus.ack[1] = (r_state == S_LOAD_A) && r_rd_valid;
  assign bus.ack[3:2] = 2'b00;
  assign bus.cin = (bus.ack[0] || bus.ack[1]) ? bus.imem_rdata : '0;

  assign bus.imem_rd   = w_rd;
  assign bus.imem_addr = ((r_state == S_LOAD_A) ? c_A_BASE : c_W_BASE) + ADDR_BW'(r_rcnt);

  assign bus.omem_wr    = w_wr;
  assign bus.omem_addr  = c_O_BASE + ADDR_BW'(r_ocnt);
  assign bus.omem_wdata = bus.cout;

  assign busy = (r_state != S_IDLE);
  assign done = w_done;

`ifdef CORELET_CTRL_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      r_perf <= 32'd0;
    end else if (busy && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_corelet_ctrl.sv
//------------------------------------------------------------------------------
// tb_corelet_ctrl : directed self-checking bench for corelet_ctrl
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_corelet_ctrl;
  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int PSUM_BW = 16;
  localparam int INST_BW = 16;
  localparam int ADDR_BW = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a_len = 8'd0;
  logic        busy;
  logic        done;
  logic [31:0] perf_cycles;

  int tests_run = 0;
  int tests_failed = 0;

  corelet_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .PSUM_BW(PSUM_BW),
                    .INST_BW(INST_BW), .ADDR_BW(ADDR_BW)) bus ();

  corelet_ctrl #(.ROWS(ROWS), .COLS(COLS), .PSUM_BW(PSUM_BW), .INST_BW(INST_BW),
                 .ADDR_BW(ADDR_BW), .W_BASE(0), .A_BASE(64), .O_BASE(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a_len       (a_len),
    .busy        (busy),
    .done        (done),
    .perf_cycles (perf_cycles),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [ADDR_BW-1:0] a);
    return 32'h5A00_0000 | {21'd0, a};
  endfunction

  function automatic logic [127:0] psum_row(input int j);
    logic [31:0] t;
    t = 32'hC0C0_0000 + j;
    return {4{t}};
  endfunction

  // Input SRAM: one-cycle read latency
  always @(posedge clk) if (bus.imem_rd) bus.imem_rdata <= word_at(bus.imem_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    #1;
    tests_run++;
    if ({busy, done, bus.ack, bus.imem_rd, bus.omem_wr} !== 8'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got busy/done/ack/rd/wr=%b expected 00000000",
               {busy, done, bus.ack, bus.imem_rd, bus.omem_wr});
    end
    tests_run++;
    if ({bus.inst, bus.cin} !== 48'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got inst=%h cin=%h expected 0", bus.inst, bus.cin);
    end
    tests_run++;
    if (perf_cycles !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_perf: got %0d expected 0", perf_cycles);
    end
    reset = 1'b0;
  endtask

  task automatic test_ignored_start;
    start = 1'b1;
    a_len = 8'd0;
    tick();
    start = 1'b0;
    #1;
    tests_run++;
    if ({busy, bus.inst} !== 17'd0) begin
      tests_failed++;
      $display("FAIL zero_len_start: got busy=%b inst=%h expected 0", busy, bus.inst);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_len_idle: got busy=%b expected 0", busy);
    end
  endtask

  // Start a tile and stream all weights; returns in the first WAIT_A cycle.
  task automatic run_weights(input logic [7:0] len);
    start = 1'b1;
    a_len = len;
    tick();
    start = 1'b0;
    #1;
    tests_run++;
    if (bus.inst !== 16'h0010 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL newcyc: got inst=%h busy=%b expected 0010 1", bus.inst, busy);
    end
    tick();
    tests_run++;
    if (bus.inst !== 16'h0000) begin
      tests_failed++;
      $display("FAIL newcyc_width: got inst=%h expected 0000", bus.inst);
    end
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    #1;
    tests_run++;
    if ({bus.imem_rd, bus.imem_addr, bus.ack} !== {1'b1, 11'd0, 4'b0000}) begin
      tests_failed++;
      $display("FAIL lw_first_rd: got rd=%b addr=%0d ack=%b expected 1 0 0000",
               bus.imem_rd, bus.imem_addr, bus.ack);
    end
    for (int k = 0; k < ROWS; k++) begin
      tick();
      tests_run++;
      if (bus.ack !== 4'b0001 || bus.cin !== word_at(11'(k))) begin
        tests_failed++;
        $display("FAIL lw_ack[%0d]: got ack=%b cin=%h expected 0001 %h",
                 k, bus.ack, bus.cin, word_at(11'(k)));
      end
      tests_run++;
      if (bus.imem_rd !== (k < ROWS - 1) ||
          (k < ROWS - 1 && bus.imem_addr !== 11'(k + 1))) begin
        tests_failed++;
        $display("FAIL lw_rd[%0d]: got rd=%b addr=%0d expected %b %0d",
                 k, bus.imem_rd, bus.imem_addr, (k < ROWS - 1), k + 1);
      end
    end
    tick();
    tests_run++;
    if ({bus.ack, bus.imem_rd, busy} !== 6'b000001 || bus.cin !== 32'd0) begin
      tests_failed++;
      $display("FAIL wait_a: got ack=%b rd=%b busy=%b cin=%h expected 0000 0 1 0",
               bus.ack, bus.imem_rd, busy, bus.cin);
    end
  endtask

  task automatic test_basic;
    logic [31:0] exp_perf;
    run_weights(8'd4);
    // start while busy, and a changed a_len, must both be ignored
    start = 1'b1;
    a_len = 8'd9;
    tick();
    start = 1'b0;
    #1;
    tests_run++;
    if ({bus.ack, bus.inst, busy} !== {4'b0, 16'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL busy_start: got ack=%b inst=%h busy=%b expected 0000 0000 1",
               bus.ack, bus.inst, busy);
    end
    tick();
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    a_len = 8'd0;
    #1;
    tests_run++;
    if ({bus.imem_rd, bus.imem_addr} !== {1'b1, 11'd64}) begin
      tests_failed++;
      $display("FAIL la_first_rd: got rd=%b addr=%0d expected 1 64", bus.imem_rd, bus.imem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (bus.ack !== 4'b0010 || bus.cin !== word_at(11'(64 + k))) begin
        tests_failed++;
        $display("FAIL la_ack[%0d]: got ack=%b cin=%h expected 0010 %h",
                 k, bus.ack, bus.cin, word_at(11'(64 + k)));
      end
    end
    tick();
    tests_run++;
    if ({bus.ack, done, bus.omem_wr, busy} !== 7'b0000001) begin
      tests_failed++;
      $display("FAIL drain_entry: got ack=%b done=%b wr=%b busy=%b expected 0000 0 0 1",
               bus.ack, done, bus.omem_wr, busy);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      bus.req = 4'b0100;
      bus.cout = psum_row(j);
      #1;
      tests_run++;
      if (bus.omem_wr !== 1'b1 || bus.omem_addr !== 11'(j) || bus.omem_wdata !== psum_row(j) ||
          done !== (j == 3)) begin
        tests_failed++;
        $display("FAIL drain_wr[%0d]: got wr=%b addr=%0d done=%b data=%h expected 1 %0d %b %h",
                 j, bus.omem_wr, bus.omem_addr, done, bus.omem_wdata, j, (j == 3), psum_row(j));
      end
    end
    tick();
    #1;
    tests_run++;
    if ({bus.omem_wr, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL done_state: got wr=%b done=%b expected 0 0", bus.omem_wr, done);
    end
    bus.req = 4'b0000;
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL back_idle: got busy=%b expected 0", busy);
    end
`ifdef CORELET_CTRL_PERF_CNT_EN
    exp_perf = 32'd25;
`else
    exp_perf = 32'd0;
`endif
    tests_run++;
    if (perf_cycles !== exp_perf) begin
      tests_failed++;
      $display("FAIL perf_tile: got %0d expected %0d", perf_cycles, exp_perf);
    end
    tick();
    tick();
    tests_run++;
    if (perf_cycles !== exp_perf) begin
      tests_failed++;
      $display("FAIL perf_hold: got %0d expected %0d", perf_cycles, exp_perf);
    end
  endtask

  task automatic test_early_drain;
    run_weights(8'd4);
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0100;
    bus.cout = psum_row(10);
    #1;
    tests_run++;
    if ({bus.omem_wr, bus.omem_addr} !== {1'b1, 11'd0} || bus.omem_wdata !== psum_row(10)) begin
      tests_failed++;
      $display("FAIL early_wr0: got wr=%b addr=%0d expected 1 0", bus.omem_wr, bus.omem_addr);
    end
    tick();
    bus.cout = psum_row(11);
    #1;
    tests_run++;
    if ({bus.omem_wr, bus.omem_addr, bus.ack} !== {1'b1, 11'd1, 4'b0010}) begin
      tests_failed++;
      $display("FAIL early_wr1: got wr=%b addr=%0d ack=%b expected 1 1 0010",
               bus.omem_wr, bus.omem_addr, bus.ack);
    end
    tick();
    bus.req = 4'b0000;
    #1;
    tests_run++;
    if (bus.omem_wr !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_idle_wr: got wr=%b expected 0", bus.omem_wr);
    end
    tick();
    tick();
    tests_run++;
    if (bus.ack !== 4'b0010 || bus.cin !== word_at(11'd67)) begin
      tests_failed++;
      $display("FAIL early_last_ack: got ack=%b cin=%h expected 0010 %h",
               bus.ack, bus.cin, word_at(11'd67));
    end
    for (int j = 2; j < 4; j++) begin
      tick();
      bus.req = 4'b0100;
      bus.cout = psum_row(10 + j);
      #1;
      tests_run++;
      if ({bus.omem_wr, bus.omem_addr, done} !== {1'b1, 11'(j), (j == 3)}) begin
        tests_failed++;
        $display("FAIL early_drain[%0d]: got wr=%b addr=%0d done=%b expected 1 %0d %b",
                 j, bus.omem_wr, bus.omem_addr, done, j, (j == 3));
      end
    end
    tick();
    bus.req = 4'b0000;
    #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_single_done: got done=%b expected 0", done);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_load;
    start = 1'b1;
    a_len = 8'd4;
    tick();
    start = 1'b0;
    tick();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (bus.ack !== 4'b0001 || bus.cin !== word_at(11'(k))) begin
        tests_failed++;
        $display("FAIL pre_reset_ack[%0d]: got ack=%b cin=%h expected 0001 %h",
                 k, bus.ack, bus.cin, word_at(11'(k)));
      end
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if ({bus.ack, busy, bus.imem_rd, done, bus.inst} !== 23'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: got ack=%b busy=%b rd=%b done=%b inst=%h expected all 0",
               bus.ack, busy, bus.imem_rd, done, bus.inst);
    end
    reset = 1'b0;
    tick();
    run_weights(8'd1);
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    #1;
    tests_run++;
    if ({bus.imem_rd, bus.imem_addr} !== {1'b1, 11'd64}) begin
      tests_failed++;
      $display("FAIL clean_la_rd: got rd=%b addr=%0d expected 1 64", bus.imem_rd, bus.imem_addr);
    end
    tick();
    bus.req = 4'b0100;
    bus.cout = psum_row(20);
    #1;
    tests_run++;
    if ({bus.ack, bus.omem_wr, bus.omem_addr} !== {4'b0010, 1'b1, 11'd0} ||
        bus.cin !== word_at(11'd64)) begin
      tests_failed++;
      $display("FAIL clean_la_ack_wr: got ack=%b wr=%b addr=%0d cin=%h expected 0010 1 0 %h",
               bus.ack, bus.omem_wr, bus.omem_addr, bus.cin, word_at(11'd64));
    end
    tick();
    bus.req = 4'b0000;
    #1;
    tests_run++;
    if ({done, bus.omem_wr, busy} !== 3'b101) begin
      tests_failed++;
      $display("FAIL drain_entry_done: got done=%b wr=%b busy=%b expected 1 0 1",
               done, bus.omem_wr, busy);
    end
    tick();
    tick();
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL clean_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  initial begin
    bus.req  = 4'b0000;
    bus.cout = '0;
    test_reset();
    test_ignored_start();
    test_basic();
    test_early_drain();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

`default_nettype wire
